// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED frame sequencer.
//   state_t  - sequencer FSM states
//   pixel_t  - packed GRB pixel {g, r, b}
//   scale_ch - per-channel brightness scaling, (c*(br+1))>>8
package led_pkg;
    localparam int CH_W  = 8;
    localparam int PIX_W = 3 * CH_W;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, LATCH, DONE} state_t;

    typedef struct packed {
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] b;
    } pixel_t;

    // br=255 multiplies by 256, so the shift returns c unchanged; br=0 gives 0.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                 input logic [CH_W-1:0] br);
        logic [15:0] p;
        p = 16'(c) * (16'(br) + 16'd1);
        return p[15:8];
    endfunction
endpackage

// File: rtl/led_frame_buf.sv
// led_frame_buf: DEPTH x 24-bit simple dual-port pixel RAM.
//   clk            - clock
//   wr_en/addr/data - write port; out-of-range addresses are dropped
//   rd_en/addr      - synchronous read request
//   rd_data         - read result, valid the cycle after rd_en, held otherwise
// No reset on the array or read register so it maps onto block RAM.
module led_frame_buf
    import led_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);
    pixel_t mem [DEPTH];
    pixel_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH)))
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: streams a NUM_LEDS pixel buffer to the led_string
// driver, waits for the driver to drain, then holds the latch gap.
//   clk, rst               - clock, async active-low reset
//   wr_en/wr_addr/wr_data  - MCU-side buffer writes (any state)
//   frame_start            - request a frame; coalesces while busy
//   pix_data/valid/ready   - pixel handshake towards the driver
//   drv_idle               - driver has shifted out every accepted bit
//   busy, frame_done       - status; frame_done pulses at end of latch gap
// Optional: LED_BRIGHTNESS_EN adds brightness[7:0], sampled per pixel at LOAD.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter  int NUM_LEDS = 16,
    parameter  int CLK_HZ   = 48_000_000,
    parameter  int LATCH_US = 80,
    localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef LED_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          frame_start,
    output logic [23:0]   pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    input  logic          drv_idle,
    output logic          busy,
    output logic          frame_done
);
    localparam int LATCH_CYCLES = (CLK_HZ / 1_000_000) * LATCH_US;
    // A zero gap still spends one cycle in LATCH.
    localparam int LC = (LATCH_CYCLES < 1) ? 1 : LATCH_CYCLES;
    localparam int CW = $clog2(LC + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LC - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          pix_valid_q, pix_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          rd_en;
    pixel_t        rd_data;
    pixel_t        pix_out;

    led_frame_buf #(.DEPTH(NUM_LEDS), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        pix_valid_d  = pix_valid_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        if (frame_start && state_q != IDLE)
            pending_d = 1'b1;
        case (state_q)
            IDLE: if (frame_start) begin
                idx_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                // Read result lands exactly as SEND begins.
                rd_en       = 1'b1;
                pix_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: if (pix_ready) begin
                pix_valid_d = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DRAIN: if (drv_idle) begin
                cnt_d   = '0;
                state_d = LATCH;
            end
            LATCH: begin
                if (cnt_q == LAST_CNT) begin
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A request arriving in this very cycle also restarts.
                if (pending_q || frame_start) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            pix_valid_q  <= pix_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LED_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_d;

    always_comb begin
        bright_d = bright_q;
        if (state_q == LOAD)
            bright_d = brightness;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bright_q <= 8'd0;
        else      bright_q <= bright_d;
    end

    // Brightness and RAM word are both registered at the LOAD edge, so the
    // scaled pixel is ready in the first SEND cycle.
    always_comb begin
        pix_out.g = scale_ch(rd_data.g, bright_q);
        pix_out.r = scale_ch(rd_data.r, bright_q);
        pix_out.b = scale_ch(rd_data.b, bright_q);
    end
`else
    assign pix_out = rd_data;
`endif

    // RAM output has no reset; gating keeps pix_data at zero outside SEND.
    assign pix_data   = pix_valid_q ? pix_out : 24'd0;
    assign pix_valid  = pix_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
module tb_led_frame_sequencer;
    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        frame_start;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        drv_idle;
    logic        busy;
    logic        frame_done;
    logic [7:0]  brightness;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] mem_m [NUM];
    logic [23:0] sb [$];

    always #5 clk = ~clk;

    led_frame_sequencer #(.NUM_LEDS(NUM), .CLK_HZ(1_000_000), .LATCH_US(5)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LED_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .drv_idle    (drv_idle),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
        int p;
        p = int'(c) * (int'(b) + 1);
        return 8'(p / 256);
    endfunction

    function automatic logic [23:0] exp_pix(input int i);
`ifdef LED_BRIGHTNESS_EN
        return {sc(mem_m[i][23:16], brightness), sc(mem_m[i][15:8], brightness),
                sc(mem_m[i][7:0], brightness)};
`else
        return mem_m[i];
`endif
    endfunction

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    // Entered at a sample point in the frame's first SEND cycle; returns at
    // the sample point where frame_done is expected high.
    task automatic serve_frame(input int stall_idx, input int stall_len, input bit extra_starts);
        int hs = 0;
        int st = 0;
        logic [23:0] held = '0;
        for (int i = 0; i < NUM; i++) sb.push_back(exp_pix(i));
        drv_idle  = 1'b0;
        pix_ready = 1'b1;
        for (int c = 0; c < 300 && hs < NUM; c++) begin
            frame_start = 1'b0;
            chk("busy_in_frame", busy, 1);
            if (pix_valid) begin
                if (hs == stall_idx && st < stall_len) begin
                    if (st == 0) begin
                        held = pix_data;
                        chk("stall_first", pix_data, sb[0]);
                    end else begin
                        chk("stall_hold", pix_data, held);
                    end
                    pix_ready = 1'b0;
                    st++;
                end else begin
                    chk("pix_data", pix_data, sb.pop_front());
                    pix_ready = 1'b1;
                    hs++;
                    if (extra_starts && (hs == 1 || hs == 2)) frame_start = 1'b1;
                end
            end else if (hs == stall_idx && st > 0) begin
                chk("stall_valid", pix_valid, 1);
            end
            step();
        end
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        if (hs < NUM) chk("frame_timeout", hs, NUM);
        chk("drain_valid", pix_valid, 0);
        chk("drain_busy", busy, 1);
        repeat (3) begin
            step();
            chk("drain_wait", frame_done, 0);
        end
        drv_idle = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("latch_gap", frame_done, 0);
            chk("latch_valid", pix_valid, 0);
        end
        step();
        chk("frame_done", frame_done, 1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_start = 1'b0; pix_ready = 1'b0; drv_idle = 1'b1; brightness = 8'd255;
        #2 rst = 1'b0;
        step(); step();
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b1;
        step();

        wr(2'd0, 24'h00CEFF);
        wr(2'd1, 24'hFF0000);
        wr(2'd2, 24'h00FF00);
        wr(2'd3, 24'h0000FF);
        step();
        chk("idle_busy", busy, 0);

        // Frame with a 7-cycle stall on pixel 1.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_valid", pix_valid, 0);
        step();
        chk("latency_valid", pix_valid, 1);
        serve_frame(1, 7, 1'b0);
        step();
        chk("done_width", frame_done, 0);
        chk("idle_after", busy, 0);

        // Requests during the frame and in DONE coalesce into one more frame.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step();
        serve_frame(-1, 0, 1'b1);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("done_to_load_busy", busy, 1);
        chk("done_to_load_valid", pix_valid, 0);
        chk("done_to_load_fd", frame_done, 0);
        step();
        chk("extra_valid", pix_valid, 1);
        serve_frame(-1, 0, 1'b0);
        step();
        chk("idle_after_extra", busy, 0);
        repeat (4) step();
        chk("no_third_frame", busy, 0);
        chk("no_third_valid", pix_valid, 0);

        // Reset while presenting the third pixel.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        pix_ready = 1'b1;
        repeat (5) step();
        chk("pre_rst_valid", pix_valid, 1);
        chk("pre_rst_data", pix_data, mem_m[2]);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", pix_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", frame_done, 0);
        step();
        chk("rst_hold_valid", pix_valid, 0);
        rst = 1'b1;
        pix_ready = 1'b0;
        repeat (5) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", pix_valid, 0);

`ifdef LED_BRIGHTNESS_EN
        wr(2'd0, 24'hC864FF);
        brightness = 8'd127;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step();
        chk("bright127", pix_data, 24'h64327F);
        serve_frame(-1, 0, 1'b0);
        step();
        brightness = 8'd255;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step();
        chk("bright255", pix_data, 24'hC864FF);
        serve_frame(-1, 0, 1'b0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
